// File: rtl/regfile_wb_ctrl.sv
// LC-3 register-file write-back controller: hazard scoreboard, issue stall and write-port arbitration.
// Optional define REGFILE_WB_BYPASS_EN lets a register cleared this cycle count as free for issue.
module regfile_wb_ctrl #(
  parameter int LOAD_DEPTH = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ISSUE_VALID,
  output logic       ISSUE_READY,
  input  logic [1:0] ISSUE_KIND,
  input  logic [2:0] ISSUE_RD,
  input  logic [2:0] ISSUE_RS1,
  input  logic [2:0] ISSUE_RS2,
  input  logic       ISSUE_USES_RS2,
  input  logic       MEM_VALID,
  output logic       MEM_ACK,
  output logic       RD_LE,
  output logic       REG_Control,
  output logic [2:0] WB_RD,
  output logic [7:0] BUSY,
  output logic       PROTO_ERR
);

  localparam int PTR_W = (LOAD_DEPTH > 1) ? $clog2(LOAD_DEPTH) : 1;
  localparam int CNT_W = $clog2(LOAD_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LOAD_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LOAD_DEPTH);

  logic [7:0]       busy_q, busy_d;
  logic             alu_v_q, alu_v_d;
  logic [2:0]       alu_rd_q, alu_rd_d;
  logic [2:0]       fifo_q [LOAD_DEPTH];
  logic [2:0]       fifo_d [LOAD_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             proto_err_q, proto_err_d;

  logic       fifo_empty_s, fifo_full_s;
  logic       load_wr_s, push_s, accept_s;
  logic       is_alu_s, is_load_s;
  logic [2:0] head_s;
  logic [7:0] clr_mask_s, set_mask_s, busy_chk_s;

  assign fifo_empty_s = (cnt_q == {CNT_W{1'b0}});
  assign fifo_full_s  = (cnt_q == CNT_FULL);
  assign head_s       = fifo_q[rd_ptr_q];
  assign is_alu_s     = (ISSUE_KIND == 2'b01);
  assign is_load_s    = (ISSUE_KIND == 2'b10);
  // ALU owns the port whenever its stage is occupied; loads wait.
  assign load_wr_s    = MEM_VALID & ~fifo_empty_s & ~alu_v_q;

  // Write-port drive and the set of scoreboard bits retired this cycle
  always_comb begin
    RD_LE       = 1'b0;
    REG_Control = 1'b0;
    WB_RD       = 3'd0;
    MEM_ACK     = 1'b0;
    clr_mask_s  = 8'h00;
    if (alu_v_q) begin
      RD_LE      = 1'b1;
      WB_RD      = alu_rd_q;
      clr_mask_s = 8'h01 << alu_rd_q;
    end else if (load_wr_s) begin
      RD_LE       = 1'b1;
      REG_Control = 1'b1;
      WB_RD       = head_s;
      MEM_ACK     = 1'b1;
      clr_mask_s  = 8'h01 << head_s;
    end else begin
      RD_LE = 1'b0;
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  assign busy_chk_s = busy_q & ~clr_mask_s;
`else
  assign busy_chk_s = busy_q;
`endif

  // Issue hazard check: RAW on sources, WAW on destination, load FIFO space
  always_comb begin
    ISSUE_READY = 1'b1;
    if (busy_chk_s[ISSUE_RS1]) begin
      ISSUE_READY = 1'b0;
    end else if (ISSUE_USES_RS2 && busy_chk_s[ISSUE_RS2]) begin
      ISSUE_READY = 1'b0;
    end else if ((is_alu_s || is_load_s) && busy_chk_s[ISSUE_RD]) begin
      ISSUE_READY = 1'b0;
    end else if (is_load_s && fifo_full_s) begin
      ISSUE_READY = 1'b0;
    end else begin
      ISSUE_READY = 1'b1;
    end
  end

  assign accept_s = ISSUE_VALID & ISSUE_READY;
  assign push_s   = accept_s & is_load_s;

  // Next-state: scoreboard, ALU stage, load FIFO and protocol error
  always_comb begin
    set_mask_s  = 8'h00;
    alu_v_d     = 1'b0;
    alu_rd_d    = 3'd0;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    fifo_d      = fifo_q;
    proto_err_d = proto_err_q | (MEM_VALID & fifo_empty_s);

    if (accept_s && (is_alu_s || is_load_s)) begin
      set_mask_s = 8'h01 << ISSUE_RD;
    end else begin
      set_mask_s = 8'h00;
    end
    // Set after clear so a bypassed re-issue keeps its bit
    busy_d = (busy_q & ~clr_mask_s) | set_mask_s;

    if (accept_s && is_alu_s) begin
      alu_v_d  = 1'b1;
      alu_rd_d = ISSUE_RD;
    end else begin
      alu_v_d  = 1'b0;
      alu_rd_d = 3'd0;
    end

    if (push_s) begin
      fifo_d[wr_ptr_q] = ISSUE_RD;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (load_wr_s) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, load_wr_s})
      2'b10:   cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_q      <= 8'h00;
      alu_v_q     <= 1'b0;
      alu_rd_q    <= 3'd0;
      rd_ptr_q    <= {PTR_W{1'b0}};
      wr_ptr_q    <= {PTR_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      proto_err_q <= 1'b0;
      for (int i = 0; i < LOAD_DEPTH; i++) begin
        fifo_q[i] <= 3'd0;
      end
    end else begin
      busy_q      <= busy_d;
      alu_v_q     <= alu_v_d;
      alu_rd_q    <= alu_rd_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      proto_err_q <= proto_err_d;
      fifo_q      <= fifo_d;
    end
  end

  assign BUSY      = busy_q;
  assign PROTO_ERR = proto_err_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed self-checking bench for regfile_wb_ctrl (LOAD_DEPTH=2), honouring REGFILE_WB_BYPASS_EN if defined.
module tb_regfile_wb_ctrl;

`ifdef REGFILE_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic       CLK, RST_N;
  logic       ISSUE_VALID, ISSUE_READY;
  logic [1:0] ISSUE_KIND;
  logic [2:0] ISSUE_RD, ISSUE_RS1, ISSUE_RS2;
  logic       ISSUE_USES_RS2;
  logic       MEM_VALID, MEM_ACK, RD_LE, REG_Control;
  logic [2:0] WB_RD;
  logic [7:0] BUSY;
  logic       PROTO_ERR;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_ctrl #(.LOAD_DEPTH(2)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_READY(ISSUE_READY),
    .ISSUE_KIND(ISSUE_KIND), .ISSUE_RD(ISSUE_RD),
    .ISSUE_RS1(ISSUE_RS1), .ISSUE_RS2(ISSUE_RS2),
    .ISSUE_USES_RS2(ISSUE_USES_RS2),
    .MEM_VALID(MEM_VALID), .MEM_ACK(MEM_ACK),
    .RD_LE(RD_LE), .REG_Control(REG_Control), .WB_RD(WB_RD),
    .BUSY(BUSY), .PROTO_ERR(PROTO_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] k, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2, input logic u2);
    ISSUE_VALID = v; ISSUE_KIND = k; ISSUE_RD = rd;
    ISSUE_RS1 = rs1; ISSUE_RS2 = rs2; ISSUE_USES_RS2 = u2;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; MEM_VALID = 1'b0;
    drive(1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0);
    #2;
    n_checks++; if (RD_LE !== 1'b0)       begin n_fail++; $display("FAIL reset_rd_le got %b exp 0", RD_LE); end
    n_checks++; if (BUSY !== 8'h00)       begin n_fail++; $display("FAIL reset_busy got %h exp 00", BUSY); end
    n_checks++; if (ISSUE_READY !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", ISSUE_READY); end
    n_checks++; if (PROTO_ERR !== 1'b0)   begin n_fail++; $display("FAIL reset_proto got %b exp 0", PROTO_ERR); end
    n_checks++; if ({MEM_ACK, REG_Control, WB_RD} !== 5'b0) begin n_fail++; $display("FAIL reset_wb got %b exp 00000", {MEM_ACK, REG_Control, WB_RD}); end
    step();
    RST_N = 1'b1;
    #1;
  endtask

  task automatic test_alu_dep();
    drive(1'b1, 2'b01, 3'd3, 3'd0, 3'd0, 1'b0);
    #1;
    n_checks++; if (ISSUE_READY !== 1'b1) begin n_fail++; $display("FAIL alu_issue_ready got %b exp 1", ISSUE_READY); end
    step();
    drive(1'b1, 2'b00, 3'd0, 3'd3, 3'd0, 1'b0);
    #1;
    n_checks++; if ({RD_LE, REG_Control, WB_RD} !== 5'b10_011) begin n_fail++; $display("FAIL alu_wb got %b exp 10011", {RD_LE, REG_Control, WB_RD}); end
    n_checks++; if (BUSY !== 8'h08)       begin n_fail++; $display("FAIL alu_busy got %h exp 08", BUSY); end
    n_checks++; if (ISSUE_READY !== BYP)  begin n_fail++; $display("FAIL alu_dep_ready got %b exp %b", ISSUE_READY, BYP); end
    step();
    ISSUE_VALID = 1'b0;
    #1;
    n_checks++; if (BUSY !== 8'h00)       begin n_fail++; $display("FAIL alu_busy_clr got %h exp 00", BUSY); end
    n_checks++; if (RD_LE !== 1'b0)       begin n_fail++; $display("FAIL alu_idle got %b exp 0", RD_LE); end
    n_checks++; if (ISSUE_READY !== 1'b1) begin n_fail++; $display("FAIL alu_dep_ready2 got %b exp 1", ISSUE_READY); end
    step();
  endtask

  task automatic test_rs2();
    drive(1'b1, 2'b01, 3'd2, 3'd0, 3'd0, 1'b0);
    step();
    drive(1'b1, 2'b00, 3'd0, 3'd0, 3'd2, 1'b0);
    #1;
    n_checks++; if (ISSUE_READY !== 1'b1) begin n_fail++; $display("FAIL rs2_unused_ready got %b exp 1", ISSUE_READY); end
    ISSUE_USES_RS2 = 1'b1;
    #1;
    n_checks++; if (ISSUE_READY !== BYP)  begin n_fail++; $display("FAIL rs2_used_ready got %b exp %b", ISSUE_READY, BYP); end
    ISSUE_VALID = 1'b0;
    step();
  endtask

  task automatic test_loads();
    drive(1'b1, 2'b10, 3'd1, 3'd0, 3'd0, 1'b0);
    step();
    drive(1'b1, 2'b10, 3'd2, 3'd0, 3'd0, 1'b0);
    #1;
    n_checks++; if (ISSUE_READY !== 1'b1) begin n_fail++; $display("FAIL ld2_ready got %b exp 1", ISSUE_READY); end
    n_checks++; if (BUSY !== 8'h02)       begin n_fail++; $display("FAIL ld1_busy got %h exp 02", BUSY); end
    step();
    drive(1'b1, 2'b10, 3'd6, 3'd0, 3'd0, 1'b0);
    #1;
    n_checks++; if (ISSUE_READY !== 1'b0) begin n_fail++; $display("FAIL ld_full_ready got %b exp 0", ISSUE_READY); end
    n_checks++; if (BUSY !== 8'h06)       begin n_fail++; $display("FAIL ld_busy got %h exp 06", BUSY); end
    n_checks++; if (RD_LE !== 1'b0)       begin n_fail++; $display("FAIL ld_idle got %b exp 0", RD_LE); end
    step();
    ISSUE_VALID = 1'b0; MEM_VALID = 1'b1;
    #1;
    n_checks++; if ({RD_LE, REG_Control, WB_RD, MEM_ACK} !== 6'b11_001_1) begin n_fail++; $display("FAIL ld_wb1 got %b exp 110011", {RD_LE, REG_Control, WB_RD, MEM_ACK}); end
    step();
    #1;
    n_checks++; if ({RD_LE, REG_Control, WB_RD, MEM_ACK} !== 6'b11_010_1) begin n_fail++; $display("FAIL ld_wb2 got %b exp 110101", {RD_LE, REG_Control, WB_RD, MEM_ACK}); end
    n_checks++; if (BUSY !== 8'h04)       begin n_fail++; $display("FAIL ld_busy_mid got %h exp 04", BUSY); end
    step();
    MEM_VALID = 1'b0;
    #1;
    n_checks++; if (BUSY !== 8'h00)       begin n_fail++; $display("FAIL ld_busy_end got %h exp 00", BUSY); end
    n_checks++; if ({RD_LE, MEM_ACK} !== 2'b00) begin n_fail++; $display("FAIL ld_end_idle got %b exp 00", {RD_LE, MEM_ACK}); end
    n_checks++; if (PROTO_ERR !== 1'b0)   begin n_fail++; $display("FAIL ld_proto got %b exp 0", PROTO_ERR); end
    step();
  endtask

  task automatic test_conflict();
    drive(1'b1, 2'b10, 3'd1, 3'd0, 3'd0, 1'b0);
    step();
    drive(1'b1, 2'b01, 3'd5, 3'd0, 3'd0, 1'b0);
    step();
    ISSUE_VALID = 1'b0; MEM_VALID = 1'b1;
    #1;
    n_checks++; if ({RD_LE, REG_Control, WB_RD, MEM_ACK} !== 6'b10_101_0) begin n_fail++; $display("FAIL cf_alu_wins got %b exp 101010", {RD_LE, REG_Control, WB_RD, MEM_ACK}); end
    n_checks++; if (BUSY !== 8'h22)       begin n_fail++; $display("FAIL cf_busy got %h exp 22", BUSY); end
    step();
    #1;
    n_checks++; if ({RD_LE, REG_Control, WB_RD, MEM_ACK} !== 6'b11_001_1) begin n_fail++; $display("FAIL cf_load got %b exp 110011", {RD_LE, REG_Control, WB_RD, MEM_ACK}); end
    n_checks++; if (BUSY !== 8'h02)       begin n_fail++; $display("FAIL cf_busy2 got %h exp 02", BUSY); end
    step();
    MEM_VALID = 1'b0;
    #1;
    n_checks++; if (BUSY !== 8'h00)       begin n_fail++; $display("FAIL cf_busy3 got %h exp 00", BUSY); end
    step();
  endtask

  task automatic test_waw();
    drive(1'b1, 2'b10, 3'd4, 3'd0, 3'd0, 1'b0);
    step();
    drive(1'b1, 2'b01, 3'd4, 3'd0, 3'd0, 1'b0);
    #1;
    n_checks++; if (ISSUE_READY !== 1'b0) begin n_fail++; $display("FAIL waw_ready1 got %b exp 0", ISSUE_READY); end
    n_checks++; if (BUSY !== 8'h10)       begin n_fail++; $display("FAIL waw_busy got %h exp 10", BUSY); end
    step();
    #1;
    n_checks++; if (ISSUE_READY !== 1'b0) begin n_fail++; $display("FAIL waw_ready2 got %b exp 0", ISSUE_READY); end
    MEM_VALID = 1'b1;
    #1;
    n_checks++; if (MEM_ACK !== 1'b1)     begin n_fail++; $display("FAIL waw_ack got %b exp 1", MEM_ACK); end
    n_checks++; if (ISSUE_READY !== BYP)  begin n_fail++; $display("FAIL waw_ready_ack got %b exp %b", ISSUE_READY, BYP); end
    step();
    ISSUE_VALID = 1'b0; MEM_VALID = 1'b0;
    #1;
    n_checks++; if (RD_LE !== BYP)        begin n_fail++; $display("FAIL waw_alu_wb got %b exp %b", RD_LE, BYP); end
    n_checks++; if (BUSY !== {3'b000, BYP, 4'h0}) begin n_fail++; $display("FAIL waw_busy2 got %h exp %h", BUSY, {3'b000, BYP, 4'h0}); end
    step();
    #1;
    n_checks++; if (BUSY !== 8'h00)       begin n_fail++; $display("FAIL waw_busy3 got %h exp 00", BUSY); end
  endtask

  task automatic test_reserved();
    drive(1'b1, 2'b11, 3'd3, 3'd0, 3'd0, 1'b0);
    #1;
    n_checks++; if (ISSUE_READY !== 1'b1) begin n_fail++; $display("FAIL rsv_ready got %b exp 1", ISSUE_READY); end
    step();
    ISSUE_VALID = 1'b0;
    #1;
    n_checks++; if ({BUSY, RD_LE} !== 9'h000) begin n_fail++; $display("FAIL rsv_nowrite got %h exp 000", {BUSY, RD_LE}); end
    step();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 2'b10, 3'd7, 3'd0, 3'd0, 1'b0);
    step();
    ISSUE_VALID = 1'b0;
    #1;
    n_checks++; if (BUSY !== 8'h80)       begin n_fail++; $display("FAIL rstm_busy_pre got %h exp 80", BUSY); end
    RST_N = 1'b0;
    #1;
    n_checks++; if (BUSY !== 8'h00)       begin n_fail++; $display("FAIL rstm_busy got %h exp 00", BUSY); end
    MEM_VALID = 1'b1;
    #1;
    n_checks++; if ({MEM_ACK, RD_LE} !== 2'b00) begin n_fail++; $display("FAIL rstm_fifo_empty got %b exp 00", {MEM_ACK, RD_LE}); end
    MEM_VALID = 1'b0;
    step();
    RST_N = 1'b1;
    #1;
    n_checks++; if (PROTO_ERR !== 1'b0)   begin n_fail++; $display("FAIL rstm_proto got %b exp 0", PROTO_ERR); end
    step();
  endtask

  task automatic test_proto();
    MEM_VALID = 1'b1;
    #1;
    n_checks++; if ({MEM_ACK, RD_LE} !== 2'b00) begin n_fail++; $display("FAIL orphan_nowrite got %b exp 00", {MEM_ACK, RD_LE}); end
    step();
    MEM_VALID = 1'b0;
    #1;
    n_checks++; if (PROTO_ERR !== 1'b1)   begin n_fail++; $display("FAIL orphan_proto got %b exp 1", PROTO_ERR); end
    step();
    step();
    n_checks++; if (PROTO_ERR !== 1'b1)   begin n_fail++; $display("FAIL orphan_sticky got %b exp 1", PROTO_ERR); end
  endtask

  initial begin
    test_reset();
    test_alu_dep();
    test_rs2();
    test_loads();
    test_conflict();
    test_waw();
    test_reserved();
    test_reset_mid();
    test_proto();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller and hazard scoreboard for the LC-3 register file datapath. It accepts decoded instructions from the control unit, stalls issue on register hazards, and schedules the single register-file write port between ALU results on Y and load data on DATA. It drives the write enable (RD_LE), the write-data mux select (REG_Control) and the write address (WB_RD) of the register block.

## Interface
- LOAD_DEPTH, 2: maximum outstanding loads; the pending-load FIFO depth, range 1..4.
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- ISSUE_VALID  in  1  decoder presents an instruction.
- ISSUE_READY  out  1  controller accepts the instruction this cycle.
- ISSUE_KIND  in  2  00 no write, 01 ALU write-back, 10 load write-back, 11 reserved (treated as 00).
- ISSUE_RD  in  3  destination register.
- ISSUE_RS1  in  3  source 1.
- ISSUE_RS2  in  3  source 2.
- ISSUE_USES_RS2  in  1  RS2 participates in the hazard check.
- MEM_VALID  in  1  load data valid on DATA; memory holds it until acknowledged.
- MEM_ACK  out  1  load data consumed this cycle.
- RD_LE  out  1  register-file write enable.
- REG_Control  out  1  0 selects Y, 1 selects DATA.
- WB_RD  out  3  register-file write address.
- BUSY  out  8  scoreboard; bit n is set while Rn has a pending write.
- PROTO_ERR  out  1  sticky: MEM_VALID arrived with no load outstanding.

## Operation
- Accept = ISSUE_VALID & ISSUE_READY.
- ISSUE_READY is 1 only when all of the following hold:
  - BUSY[RS1] = 0.
  - ISSUE_USES_RS2 = 0, or BUSY[RS2] = 0.
  - For KIND 01/10: BUSY[RD] = 0 (WAW blocked).
  - For KIND 10: the FIFO is not full.
- ISSUE_READY is combinational from the registered state. It does not depend on ISSUE_VALID.
- ALU path:
  - On accept with KIND 01, set BUSY[RD] and load the one-entry WB stage (alu_v=1, alu_rd=RD).
  - In the next cycle, RD_LE=1, REG_Control=0, WB_RD=alu_rd.
  - BUSY[alu_rd] clears at the end of that cycle.
  - Y must be valid in that cycle.
- Load path:
  - On accept with KIND 10, set BUSY[RD] and push RD into the in-order FIFO.
  - A load write occurs when MEM_VALID=1, the FIFO is non-empty and alu_v=0. In that cycle: RD_LE=1, REG_Control=1, WB_RD=FIFO head, MEM_ACK=1. The FIFO pops and BUSY[head] clears.
- Port conflict:
  - ALU always wins. When alu_v=1 and MEM_VALID=1, MEM_ACK=0 and the memory holds DATA.
  - Back-to-back ALU issues can starve loads. This is accepted.
- Idle outputs: with no write, RD_LE=0, REG_Control=0, WB_RD=0.
- Simultaneous push and pop on a full FIFO: no push, because ISSUE_READY was already 0. Push and pop on a non-full FIFO happen in the same cycle with the count unchanged.
- Same register clearing and being re-issued in one cycle: stall one cycle. There is no bypass unless the macro below is defined.
- Orphan load data: MEM_VALID=1 with an empty FIFO sets PROTO_ERR. MEM_ACK stays 0 and there is no write.
- Reserved KIND 11: accepted as a no-write instruction. No scoreboard change.

## Timing
- Reset values:
  - Registered state: BUSY=0, FIFO empty, alu_v=0, PROTO_ERR=0.
  - Resulting outputs: RD_LE=0, MEM_ACK=0, REG_Control=0, WB_RD=0, ISSUE_READY=1.
- Reset mid-operation drops all pending writes immediately. The memory must be reset alongside.
- Latency:
  - ALU write happens 1 cycle after accept.
  - Load write happens in the cycle MEM_VALID is seen, at the earliest 1 cycle after accept, because the FIFO push is registered.
- Output types:
  - RD_LE, REG_Control, WB_RD and MEM_ACK are combinational from registered state plus MEM_VALID.
  - BUSY and PROTO_ERR are registered.
- FIFO pointers wrap modulo LOAD_DEPTH. Occupancy uses a count register of width clog2(LOAD_DEPTH+1).

## Configuration
- REGFILE_WB_BYPASS_EN:
  - Defined: a BUSY bit being cleared in the current cycle (ALU write or acked load) counts as free for the ISSUE_READY check. A dependent instruction can then issue in the write cycle.
  - Undefined: ISSUE_READY uses registered BUSY only, which adds a 1-cycle stall.

## Test plan
- Reset with MEM_VALID=0 -> RD_LE=0, BUSY=00, ISSUE_READY=1, PROTO_ERR=0. Assert RST_N low mid-load -> BUSY=00 and FIFO empty on the same edge.
- Issue ALU RD=3, then next cycle an instruction with RS1=3 -> first cycle RD_LE=1, WB_RD=3, REG_Control=0. Dependent instruction: ISSUE_READY=0 for 1 cycle without the macro, 1 with REGFILE_WB_BYPASS_EN.
- Issue loads RD=1 then RD=2 (LOAD_DEPTH=2), then a third load -> third load stalls. BUSY=06. Two MEM_VALID pulses write WB_RD=1 then 2 with REG_Control=1, and BUSY returns to 00.
- ALU write-back to R5 in the same cycle as MEM_VALID for pending R1 -> that cycle WB_RD=5, MEM_ACK=0. Next cycle WB_RD=1, MEM_ACK=1.
- MEM_VALID=1 with no load outstanding -> PROTO_ERR=1 and stays 1. RD_LE=0, MEM_ACK=0.
- Issue ALU RD=4 while BUSY[4]=1 from a pending load -> ISSUE_READY=0 until the load is acked.
